// File: rtl/gorev_sirala.sv
// Task sequencer for the image task unit: queues host tasks, issues the start pulse, streams one frame,
// counts returned pixels and reports done or drain timeout. Optional cycle counter: GOREV_PERF_EN.
`ifndef GRV4_H
`define GRV4_H 3'd4
`endif

module gorev_sirala #(
    parameter int GRV_BIT         = 3,
    parameter int PIXEL_BIT       = 24,
    parameter int PIKSEL_SAYISI   = 76800,
    parameter int HIST_CIKIS      = 256,
    parameter int KUYRUK_DERINLIK = 4,
    parameter int ZAMAN_ASIMI     = 1024
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 gorev_gecerli_i,
    input  logic [GRV_BIT-1:0]   gorev_i,
    output logic                 gorev_hazir_o,
    input  logic                 kaynak_etkin_i,
    input  logic [PIXEL_BIT-1:0] kaynak_pixel_i,
    output logic                 kaynak_hazir_o,
    output logic                 gb_basla_o,
    output logic [GRV_BIT-1:0]   gb_gorev_o,
    output logic                 gb_etkin_o,
    output logic [PIXEL_BIT-1:0] gb_pixel_o,
    output logic                 gb_stal_o,
    input  logic                 gb_etkin_i,
    input  logic [PIXEL_BIT-1:0] gb_pixel_i,
    output logic                 hedef_etkin_o,
    output logic [PIXEL_BIT-1:0] hedef_pixel_o,
    input  logic                 hedef_hazir_i,
    output logic                 mesgul_o,
    output logic                 bitti_o,
    output logic                 hata_o,
    output logic [31:0]          perf_cevrim_o
);

    // The histogram count is folded into the width so a short frame can still count 256 results.
    localparam int MAX_PZ  = (PIKSEL_SAYISI > ZAMAN_ASIMI) ? PIKSEL_SAYISI : ZAMAN_ASIMI;
    localparam int MAX_ALL = (MAX_PZ > HIST_CIKIS) ? MAX_PZ : HIST_CIKIS;
    localparam int CW      = $clog2(MAX_ALL) + 1;
    localparam int AW      = $clog2(KUYRUK_DERINLIK);

    localparam logic [CW-1:0] SAT      = '1;
    localparam logic [CW-1:0] PIK_N    = CW'(PIKSEL_SAYISI);
    localparam logic [CW-1:0] PIK_SON  = CW'(PIKSEL_SAYISI - 1);
    localparam logic [CW-1:0] HIST_N   = CW'(HIST_CIKIS);
    localparam logic [CW-1:0] ZAMAN_N  = CW'(ZAMAN_ASIMI);

    typedef enum logic [2:0] {
        BOS    = 3'd0,
        BASLAT = 3'd1,
        BEKLE  = 3'd2,
        AKIS   = 3'd3,
        BOSALT = 3'd4,
        BITTI  = 3'd5
    } durum_t;

    durum_t durum;

    logic [GRV_BIT-1:0] kuyruk [KUYRUK_DERINLIK];
    logic [AW:0]        yaz_ptr, oku_ptr;
    logic               kuyruk_bos, kuyruk_dolu, push;

    logic [CW-1:0] giris_sayac, cikis_sayac, bos_sayac;
    logic [CW-1:0] giris_next, cikis_next, bos_next, beklenen;
    logic          akis, aktif;

    assign kuyruk_bos    = (yaz_ptr == oku_ptr);
    assign kuyruk_dolu   = (yaz_ptr[AW] != oku_ptr[AW]) && (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]);
    assign gorev_hazir_o = !kuyruk_dolu;
    assign push          = gorev_gecerli_i && !kuyruk_dolu;

    assign akis           = (durum == AKIS);
    assign aktif          = (durum == AKIS) || (durum == BOSALT);
    assign gb_stal_o      = aktif && !hedef_hazir_i;
    assign kaynak_hazir_o = akis && hedef_hazir_i && (giris_sayac < PIK_N);
    assign gb_etkin_o     = kaynak_etkin_i && kaynak_hazir_o;
    assign gb_pixel_o     = kaynak_pixel_i;
    // Results outside an active frame are dropped rather than forwarded.
    assign hedef_etkin_o  = aktif && gb_etkin_i && !gb_stal_o;
    assign hedef_pixel_o  = gb_pixel_i;

    assign beklenen   = (gb_gorev_o == GRV_BIT'(`GRV4_H)) ? HIST_N : PIK_N;
    assign giris_next = (gb_etkin_o && giris_sayac != SAT) ? giris_sayac + CW'(1) : giris_sayac;
    assign cikis_next = (hedef_etkin_o && cikis_sayac != SAT) ? cikis_sayac + CW'(1) : cikis_sayac;
    assign bos_next   = hedef_etkin_o ? '0 :
                        (gb_stal_o || bos_sayac == SAT) ? bos_sayac : bos_sayac + CW'(1);

    always_ff @(posedge clk_i) begin
        if (push) kuyruk[yaz_ptr[AW-1:0]] <= gorev_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum       <= BOS;
            yaz_ptr     <= '0;
            oku_ptr     <= '0;
            gb_basla_o  <= 1'b0;
            gb_gorev_o  <= '0;
            mesgul_o    <= 1'b0;
            bitti_o     <= 1'b0;
            hata_o      <= 1'b0;
            giris_sayac <= '0;
            cikis_sayac <= '0;
            bos_sayac   <= '0;
        end else begin
            if (push) yaz_ptr <= yaz_ptr + (AW+1)'(1);
            gb_basla_o <= 1'b0;
            bitti_o    <= 1'b0;
            case (durum)
                BOS: if (!kuyruk_bos) begin
                    durum       <= BASLAT;
                    gb_basla_o  <= 1'b1;
                    gb_gorev_o  <= kuyruk[oku_ptr[AW-1:0]];
                    mesgul_o    <= 1'b1;
                    hata_o      <= 1'b0;
                    giris_sayac <= '0;
                    cikis_sayac <= '0;
                    bos_sayac   <= '0;
                end
                BASLAT: begin
                    oku_ptr <= oku_ptr + (AW+1)'(1);
                    durum   <= BEKLE;
                end
                BEKLE: durum <= AKIS;
                AKIS: begin
                    giris_sayac <= giris_next;
                    cikis_sayac <= cikis_next;
                    if (gb_etkin_o && giris_sayac == PIK_SON) durum <= BOSALT;
                end
                BOSALT: begin
                    cikis_sayac <= cikis_next;
                    bos_sayac   <= bos_next;
                    if (cikis_next >= beklenen) begin
                        durum   <= BITTI;
                        bitti_o <= 1'b1;
                    end else if (bos_next >= ZAMAN_N) begin
                        durum   <= BITTI;
                        bitti_o <= 1'b1;
                        hata_o  <= 1'b1;
                    end
                end
                BITTI: begin
                    durum    <= BOS;
                    mesgul_o <= 1'b0;
                end
                default: durum <= BOS;
            endcase
        end
    end

`ifdef GOREV_PERF_EN
    logic [31:0] perf_sayac, perf_r;

    // Loaded with 1 in BASLAT so the value seen in BITTI is the BASLAT-to-BITTI distance.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            perf_sayac <= '0;
            perf_r     <= '0;
        end else begin
            if (durum == BASLAT) perf_sayac <= 32'd1;
            else if (durum != BOS && perf_sayac != 32'hFFFF_FFFF) perf_sayac <= perf_sayac + 32'd1;
            if (durum == BITTI) perf_r <= perf_sayac;
        end
    end

    assign perf_cevrim_o = perf_r;
`else
    assign perf_cevrim_o = 32'd0;
`endif

endmodule

// File: tb/tb_gorev_sirala.sv
// Directed bench for gorev_sirala: small frame, echo/histogram/dropping unit model, stall,
// timeout, queue-full and mid-task reset steps.
module tb_gorev_sirala;

    localparam int GB    = 3;
    localparam int PB    = 24;
    localparam int NPIX  = 16;
    localparam int NHIST = 256;
    localparam int ZA    = 8;
    localparam int LAT   = 5;
    localparam logic [GB-1:0] T_M = 3'd3;
    localparam logic [GB-1:0] T_H = 3'd4;
    localparam int M_ECHO = 0;
    localparam int M_HIST = 1;
    localparam int M_DROP = 2;

    logic          clk_i, rstn_i;
    logic          gorev_gecerli_i, gorev_hazir_o;
    logic [GB-1:0] gorev_i, gb_gorev_o;
    logic          kaynak_etkin_i, kaynak_hazir_o;
    logic [PB-1:0] kaynak_pixel_i, gb_pixel_o, gb_pixel_i, hedef_pixel_o;
    logic          gb_basla_o, gb_etkin_o, gb_stal_o, gb_etkin_i;
    logic          hedef_etkin_o, hedef_hazir_i;
    logic          mesgul_o, bitti_o, hata_o;
    logic [31:0]   perf_cevrim_o;

    int total = 0;
    int bad   = 0;

    gorev_sirala #(
        .GRV_BIT(GB), .PIXEL_BIT(PB), .PIKSEL_SAYISI(NPIX), .HIST_CIKIS(NHIST),
        .KUYRUK_DERINLIK(4), .ZAMAN_ASIMI(ZA)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .gorev_gecerli_i(gorev_gecerli_i), .gorev_i(gorev_i), .gorev_hazir_o(gorev_hazir_o),
        .kaynak_etkin_i(kaynak_etkin_i), .kaynak_pixel_i(kaynak_pixel_i), .kaynak_hazir_o(kaynak_hazir_o),
        .gb_basla_o(gb_basla_o), .gb_gorev_o(gb_gorev_o), .gb_etkin_o(gb_etkin_o),
        .gb_pixel_o(gb_pixel_o), .gb_stal_o(gb_stal_o),
        .gb_etkin_i(gb_etkin_i), .gb_pixel_i(gb_pixel_i),
        .hedef_etkin_o(hedef_etkin_o), .hedef_pixel_o(hedef_pixel_o), .hedef_hazir_i(hedef_hazir_i),
        .mesgul_o(mesgul_o), .bitti_o(bitti_o), .hata_o(hata_o), .perf_cevrim_o(perf_cevrim_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Task unit model: fixed-latency echo frozen by stall, or histogram burst, or echo dropping the first 6.
    int            mode = M_ECHO;
    logic          pv [LAT];
    logic [PB-1:0] pp [LAT];
    int            in_seen;
    int            hist_left;

    always @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
            in_seen   <= 0;
            hist_left <= 0;
        end else begin
            if (!gb_stal_o) begin
                pv[0] <= gb_etkin_o && (mode == M_ECHO || (mode == M_DROP && in_seen >= 6));
                pp[0] <= gb_pixel_o;
                for (int i = 1; i < LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pp[i] <= pp[i-1];
                end
                if (mode == M_HIST && gb_etkin_o && in_seen == NPIX - 1) hist_left <= NHIST;
                else if (hist_left > 0) hist_left <= hist_left - 1;
            end
            if (gb_basla_o) in_seen <= 0;
            else if (gb_etkin_o) in_seen <= in_seen + 1;
        end
    end

    assign gb_etkin_i = pv[LAT-1] || (hist_left > 0);
    assign gb_pixel_i = pv[LAT-1] ? pp[LAT-1] : PB'(hist_left);

    // Monitor: per-task event record sampled on the falling edge.
    int cyc = 0;
    int basla_cnt = 0, bitti_cnt = 0, basla_double = 0;
    int basla_cyc = 0, bitti_cyc = 0, first_in_cyc = -1, last_out_cyc = 0;
    int in_cnt = 0, out_cnt = 0, stall_cnt = 0, viol = 0;
    logic prev_basla = 1'b0;
    logic hata_at_bitti = 1'b0, hata_at_basla = 1'b0;
    logic [GB-1:0] obs_q [$];

    always @(negedge clk_i) begin
        cyc++;
        if (gb_basla_o && prev_basla) basla_double++;
        prev_basla = gb_basla_o;
        if (gb_basla_o) begin
            basla_cnt++;
            basla_cyc     = cyc;
            in_cnt        = 0;
            out_cnt       = 0;
            stall_cnt     = 0;
            viol          = 0;
            first_in_cyc  = -1;
            hata_at_basla = hata_o;
            obs_q.push_back(gb_gorev_o);
        end
        if (gb_etkin_o) begin
            in_cnt++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        if (hedef_etkin_o) begin
            out_cnt++;
            last_out_cyc = cyc;
        end
        if (gb_stal_o) begin
            stall_cnt++;
            if (kaynak_hazir_o || gb_etkin_o || hedef_etkin_o) viol++;
        end
        if (bitti_o) begin
            bitti_cnt++;
            bitti_cyc     = cyc;
            hata_at_bitti = hata_o;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
        kaynak_pixel_i = PB'($urandom);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [GB-1:0] code);
        gorev_gecerli_i = 1'b1;
        gorev_i         = code;
        tick();
        gorev_gecerli_i = 1'b0;
    endtask

    task automatic wait_basla(input int target, input string tag);
        for (int i = 0; i < 200 && basla_cnt < target; i++) tick();
        chk(tag, 32'(basla_cnt >= target), 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 800 && bitti_cnt < target; i++) tick();
        chk(tag, 32'(bitti_cnt >= target), 1);
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] perf_exp();
`ifdef GOREV_PERF_EN
        return 32'(bitti_cyc - basla_cyc);
`else
        return 32'd0;
`endif
    endfunction

    // scoreboard of issued task codes
    logic [GB-1:0] exp_q [$];
    int b0, bs0;
    logic acc;
    int acc_basla;

    initial begin
        rstn_i = 1'b0; gorev_gecerli_i = 1'b0; gorev_i = '0;
        kaynak_etkin_i = 1'b1; kaynak_pixel_i = '0; hedef_hazir_i = 1'b1;
        repeat (3) tick();
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst_hazir", 32'(gorev_hazir_o), 1);
        chk("rst_ctl", 32'({mesgul_o, gb_basla_o, bitti_o, hata_o, kaynak_hazir_o,
                            gb_etkin_o, gb_stal_o, hedef_etkin_o}), 0);
        chk("rst_gorev", 32'(gb_gorev_o), 0);
        chk("rst_perf", perf_cevrim_o, 0);

        // single task, plain flow
        mode = M_ECHO;
        tick();
        push(T_M);
        wait_done(1, "t1_done");
        chk("t1_basla_cnt", 32'(basla_cnt), 1);
        chk("t1_basla_width", 32'(basla_double), 0);
        chk("t1_code", 32'(obs_q[0]), 32'(T_M));
        chk("t1_first_in", 32'(first_in_cyc - basla_cyc), 2);
        chk("t1_in", 32'(in_cnt), NPIX);
        chk("t1_out", 32'(out_cnt), NPIX);
        chk("t1_bitti_lat", 32'(bitti_cyc - last_out_cyc), 1);
        chk("t1_total_lat", 32'(bitti_cyc - basla_cyc), 23);
        chk("t1_hata", 32'(hata_at_bitti), 0);
        chk("t1_perf", perf_cevrim_o, perf_exp());
        chk("t1_idle", 32'(mesgul_o), 0);

        // queue fill and FIFO order
        obs_q.delete();
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        b0 = bitti_cnt; bs0 = basla_cnt;
        push(3'd1);
        wait_basla(bs0 + 1, "t2_start");
        push(3'd2); push(3'd3); push(3'd5); push(3'd6);
        @(negedge clk_i);
        chk("t2_full", 32'(gorev_hazir_o), 0);
        gorev_gecerli_i = 1'b1;
        gorev_i = 3'd7;
        acc = 1'b0;
        acc_basla = 0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk_i);
            if (gorev_hazir_o) begin
                acc = 1'b1;
                acc_basla = basla_cnt;
            end
            tick();
        end
        gorev_gecerli_i = 1'b0;
        chk("t2_accept", 32'(acc), 1);
        chk("t2_after_pop", 32'(acc_basla), 32'(bs0 + 2));
        wait_done(b0 + 6, "t2_done");
        chk("t2_count", 32'(obs_q.size()), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("t2_order", 32'(obs_q[i]), 32'(exp_q[i]));

        // 3-cycle sink backpressure in mid-frame
        b0 = bitti_cnt; bs0 = basla_cnt;
        push(T_M);
        for (int i = 0; i < 200 && !(basla_cnt > bs0 && in_cnt >= 6); i++) tick();
        chk("t3_mid", 32'(in_cnt >= 6), 1);
        hedef_hazir_i = 1'b0;
        repeat (3) tick();
        hedef_hazir_i = 1'b1;
        wait_done(b0 + 1, "t3_done");
        chk("t3_stall", 32'(stall_cnt), 3);
        chk("t3_viol", 32'(viol), 0);
        chk("t3_in", 32'(in_cnt), NPIX);
        chk("t3_out", 32'(out_cnt), NPIX);
        chk("t3_hata", 32'(hata_at_bitti), 0);
        chk("t3_perf", perf_cevrim_o, perf_exp());

        // histogram task: 256 results after the frame
        mode = M_HIST;
        b0 = bitti_cnt;
        push(T_H);
        wait_done(b0 + 1, "t4_done");
        chk("t4_in", 32'(in_cnt), NPIX);
        chk("t4_out", 32'(out_cnt), NHIST);
        chk("t4_bitti_lat", 32'(bitti_cyc - last_out_cyc), 1);
        chk("t4_hata", 32'(hata_at_bitti), 0);

        // drain timeout: 10 of 16 results return
        mode = M_DROP;
        b0 = bitti_cnt;
        push(T_M);
        wait_done(b0 + 1, "t5_done");
        chk("t5_out", 32'(out_cnt), 10);
        chk("t5_hata", 32'(hata_at_bitti), 1);
        chk("t5_bitti_lat", 32'(bitti_cyc - last_out_cyc), 32'(ZA + 1));
        chk("t5_hata_hold", 32'(hata_o), 1);
        mode = M_ECHO;
        b0 = bitti_cnt; bs0 = basla_cnt;
        push(T_M);
        wait_basla(bs0 + 1, "t5_restart");
        chk("t5_hata_clr", 32'(hata_at_basla), 0);
        wait_done(b0 + 1, "t5_done2");
        chk("t5_hata2", 32'(hata_at_bitti), 0);

        // reset mid-frame with two tasks queued
        b0 = bitti_cnt; bs0 = basla_cnt;
        push(T_M);
        wait_basla(bs0 + 1, "t6_start");
        push(3'd5); push(3'd6);
        for (int i = 0; i < 200 && in_cnt < 4; i++) tick();
        chk("t6_in_akis", 32'(in_cnt >= 4), 1);
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("t6_ctl", 32'({mesgul_o, gb_basla_o, bitti_o, hata_o, kaynak_hazir_o,
                           gb_etkin_o, gb_stal_o, hedef_etkin_o}), 0);
        chk("t6_hazir", 32'(gorev_hazir_o), 1);
        chk("t6_gorev", 32'(gb_gorev_o), 0);
        chk("t6_perf", perf_cevrim_o, 0);
        bs0 = basla_cnt;
        repeat (40) tick();
        chk("t6_no_start", 32'(basla_cnt), 32'(bs0));
        chk("t6_no_bitti", 32'(bitti_cnt), 32'(b0));
        chk("end_basla_width", 32'(basla_double), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
